// File: rtl/posit_align_es3_pkg.sv
// posit_align_es3_pkg: shared widths, operand/result structs and the significand helper for the ES=3 posit adder.
// Provides package posit_defines_es3, which every posit_align_es3 file imports.
package posit_defines_es3;
    localparam int NBITS = 32;
    localparam int ES    = 3;
    localparam int FBITS = NBITS - ES - 3;
    localparam int AW    = FBITS + 4;

    typedef struct packed {
        logic              sign;
        logic signed [8:0] scale;
        logic [FBITS-1:0]  fraction;
        logic              inf;
        logic              zero;
    } value;

    typedef struct packed {
        logic              sgn_l;
        logic              sgn_s;
        logic signed [8:0] scale;
        logic [AW-1:0]     frac_l;
        logic [AW-1:0]     frac_s;
        logic              eff_sub;
        logic              inf;
        logic              zero;
    } aligned_t;

    // Ordered operand pair held between the compare and shift stages.
    typedef struct packed {
        logic              sgn_l;
        logic              sgn_s;
        logic signed [8:0] scale;
        logic [AW-1:0]     sig_l;
        logic [AW-1:0]     sig_s;
        logic [9:0]        shamt;
        logic              inf;
        logic              zero;
    } s1_t;

    // Hidden bit, stored fraction, then empty G/R/S positions.
    function automatic logic [AW-1:0] significand(value v);
        return {~v.zero, v.fraction, 3'b000};
    endfunction
endpackage

// File: rtl/posit_align_es3_shift.sv
// shift_right_sticky: logical right shift that folds every shifted-out bit into the result LSB.
// Ports: a_i operand, shamt_i shift amount (any value, >= N flushes to the sticky bit), c result.
module shift_right_sticky #(
    parameter int N = 30,
    parameter int S = 10
) (
    input  logic [N-1:0] a_i,
    input  logic [S-1:0] shamt_i,
    output logic [N-1:0] c
);
    logic [N-1:0] lost;

    // Mask of the bits that fall off the bottom; all ones once shamt_i >= N.
    assign lost = a_i & ~({N{1'b1}} << shamt_i);
    assign c    = (a_i >> shamt_i) | {{(N-1){1'b0}}, |lost};
endmodule

// File: rtl/posit_align_es3.sv
// posit_align_es3: 2-stage valid/ready alignment of two decoded ES=3 posit operands (order by magnitude, sticky right shift).
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in1/in2 operand pair; out_valid/out_ready/out aligned pair.
module posit_align_es3
    import posit_defines_es3::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     in_valid,
    output logic     in_ready,
    input  value     in1,
    input  value     in2,
    output logic     out_valid,
    input  logic     out_ready,
    output aligned_t out
);
    logic            s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic            s1_adv, s2_adv;
    s1_t             s1_q, s1_d, c1;
    aligned_t        s2_q, s2_d, c2;
    logic signed [9:0] diff;
    logic [9:0]      adiff;
    logic            swap, any_inf, both_zero;
    value            l, s;
    logic [AW-1:0]   frac_s;

    always_comb begin
        diff      = {in1.scale[8], in1.scale} - {in2.scale[8], in2.scale};
        adiff     = diff[9] ? -diff : diff;
        any_inf   = in1.inf | in2.inf;
        both_zero = in1.zero & in2.zero;
        // A lone zero operand always ranks smaller; otherwise compare scale, then fraction.
        swap = (in1.zero != in2.zero) ? in1.zero
             : (diff[9] | ((diff == '0) & (in2.fraction > in1.fraction)));
        l = swap ? in2 : in1;
        s = swap ? in1 : in2;
        c1 = '0;
        c1.sgn_l = l.sign;
        c1.sgn_s = s.sign;
        c1.inf   = any_inf;
        c1.zero  = ~any_inf & both_zero;
        c1.scale = (any_inf | both_zero) ? '0 : l.scale;
        c1.sig_l = (any_inf | both_zero) ? '0 : significand(l);
        c1.sig_s = (any_inf | s.zero) ? '0 : significand(s);
        c1.shamt = (any_inf | s.zero) ? '0 : adiff;
    end

    shift_right_sticky #(.N(AW), .S(10)) u_shift (
        .a_i     (s1_q.sig_s),
        .shamt_i (s1_q.shamt),
        .c       (frac_s)
    );

    always_comb begin
        c2 = '0;
        c2.sgn_l   = s1_q.sgn_l;
        c2.sgn_s   = s1_q.sgn_s;
        c2.scale   = s1_q.scale;
        c2.frac_l  = s1_q.sig_l;
        c2.frac_s  = frac_s;
        c2.eff_sub = ~s1_q.inf & (s1_q.sgn_l ^ s1_q.sgn_s);
        c2.inf     = s1_q.inf;
        c2.zero    = s1_q.zero;
    end

    always_comb begin
        s2_adv     = ~s2_valid_q | out_ready;
        s1_adv     = ~s1_valid_q | s2_adv;
        s1_valid_d = s1_adv ? in_valid : s1_valid_q;
        s1_d       = (s1_adv & in_valid) ? c1 : s1_q;
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        s2_d       = (s2_adv & s1_valid_q) ? c2 : s2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign out       = s2_q;
endmodule

// File: tb/tb_posit_align_es3.sv
// tb_posit_align_es3: directed table, scripted handshake sequences and randomized scoreboard checks for posit_align_es3.
module tb_posit_align_es3;
    import posit_defines_es3::*;

    typedef struct { value a; value b; aligned_t e; int kind; } vec_t;
    typedef struct { aligned_t e; int kind; } exp_t;

    logic     clk = 1'b0;
    logic     reset, in_valid, in_ready, out_valid, out_ready;
    value     in1, in2;
    aligned_t out;
    int       checks = 0;
    int       errors = 0;
    exp_t     q[$];
    logic     hold_chk = 1'b0;
    aligned_t held;
    exp_t     dummy;
    vec_t     vecs[$];

    always #5 clk = ~clk;

    posit_align_es3 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic value mk(logic sg, int sc, int fr, logic inf = 1'b0, logic zr = 1'b0);
        value v;
        v.sign = sg; v.scale = 9'(sc); v.fraction = 26'(fr); v.inf = inf; v.zero = zr;
        return v;
    endfunction

    function automatic aligned_t ma(logic sl, logic ss, int sc, logic [29:0] fl, logic [29:0] fs,
                                    logic ef, logic inf, logic zr);
        aligned_t r;
        r.sgn_l = sl; r.sgn_s = ss; r.scale = 9'(sc); r.frac_l = fl; r.frac_s = fs;
        r.eff_sub = ef; r.inf = inf; r.zero = zr;
        return r;
    endfunction

    // Reference: order by value, then divide the smaller significand by 2^d and keep any remainder as sticky.
    function automatic exp_t model(value a, value b);
        exp_t   r;
        value   l, s;
        int     sa, sb, d;
        bit     a_big;
        longint sig, p;
        r.e = '0; r.kind = 0;
        if (a.inf || b.inf) begin r.kind = 1; r.e.inf = 1'b1; return r; end
        if (a.zero && b.zero) begin r.kind = 2; r.e.zero = 1'b1; return r; end
        sa = $signed(a.scale);
        sb = $signed(b.scale);
        if (b.zero) a_big = 1;
        else if (a.zero) a_big = 0;
        else a_big = (sa > sb) || (sa == sb && a.fraction >= b.fraction);
        l = a_big ? a : b;
        s = a_big ? b : a;
        d = (sa > sb) ? sa - sb : sb - sa;
        r.e.sgn_l   = l.sign;
        r.e.sgn_s   = s.sign;
        r.e.scale   = l.scale;
        r.e.eff_sub = l.sign != s.sign;
        r.e.frac_l  = 30'(longint'(536870912) + longint'(l.fraction) * 8);
        if (!s.zero) begin
            sig = longint'(536870912) + longint'(s.fraction) * 8;
            if (d >= 30) r.e.frac_s = 30'd1;
            else begin
                p = longint'(1) << d;
                r.e.frac_s = 30'(sig / p) | 30'((sig % p) != 0);
            end
        end
        return r;
    endfunction

    // kind 1 (inf): signs are unspecified; kind 2 (both zero): only inf/zero/fractions are specified.
    function automatic bit same(aligned_t g, aligned_t e, int kind);
        if (kind >= 1) begin g.sgn_l = 0; g.sgn_s = 0; e.sgn_l = 0; e.sgn_s = 0; end
        if (kind == 2) begin g.scale = 0; g.eff_sub = 0; e.scale = 0; e.eff_sub = 0; end
        return g === e;
    endfunction

    task automatic chk(string nm, logic [73:0] got, logic [73:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick(input bit use_tx, input exp_t tx, output bit fired);
        exp_t e;
        #1;
        fired = 0;
        if (reset) begin
            q.delete();
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) chk("hold", out, held);
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stale: unexpected output %h", out);
                end else begin
                    e = q.pop_front();
                    if (!same(out, e.e, e.kind)) begin
                        errors++;
                        $display("FAIL out: got %h expected %h (kind %0d)", out, e.e, e.kind);
                    end
                end
            end
            if (in_valid && in_ready) begin
                fired = 1;
                if (use_tx) q.push_back(tx);
                else q.push_back(model(in1, in2));
            end
            hold_chk = out_valid && !out_ready;
            held = out;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input value a, input value b, input bit use_tx, input exp_t tx);
        bit f = 0;
        in1 = a; in2 = b; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick(use_tx, tx, f);
            if (f) break;
        end
        in_valid = 1'b0;
        if (!f) begin
            checks++; errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1");
        end
    endtask

    task automatic drain();
        bit f;
        out_ready = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (q.size() == 0) break;
            tick(0, dummy, f);
        end
        chk("drain", 74'(q.size()), 74'd0);
    endtask

    function automatic value rv(int base);
        value v;
        int   sc;
        sc = base + int'($urandom_range(0, 70)) - 35;
        if (sc > 255) sc = 255;
        if (sc < -256) sc = -256;
        v.sign = 1'($urandom_range(0, 1));
        v.scale = 9'(sc);
        v.fraction = ($urandom_range(0, 3) == 0) ? 26'($urandom_range(0, 7)) : 26'($urandom);
        v.inf = ($urandom_range(0, 30) == 0);
        v.zero = ($urandom_range(0, 15) == 0);
        return v;
    endfunction

    initial begin
        bit   f;
        exp_t tx;
        value a, b;
        int   base;
        vecs.push_back('{mk(0,5,0),   mk(0,2,0),   ma(0,0,5,30'h20000000,30'h04000000,0,0,0), 0});
        vecs.push_back('{mk(0,6,0),   mk(0,2,1),   ma(0,0,6,30'h20000000,30'h02000001,0,0,0), 0});
        vecs.push_back('{mk(0,2,1),   mk(1,6,0),   ma(1,0,6,30'h20000000,30'h02000001,1,0,0), 0});
        vecs.push_back('{mk(0,40,0),  mk(0,0,0),   ma(0,0,40,30'h20000000,30'h00000001,0,0,0), 0});
        vecs.push_back('{mk(0,0,0,0,1), mk(0,-3,0), ma(0,0,-3,30'h20000000,30'h0,0,0,0), 0});
        vecs.push_back('{mk(0,0,0,0,1), mk(0,0,0,0,1), ma(0,0,0,30'h0,30'h0,0,0,1), 2});
        vecs.push_back('{mk(0,1,'h100), mk(0,1,'h200), ma(0,0,1,30'h20001000,30'h20000800,0,0,0), 0});
        vecs.push_back('{mk(0,1,'h100), mk(0,1,0,1,0), ma(0,0,0,30'h0,30'h0,0,1,0), 1});
        vecs.push_back('{mk(0,28,0),  mk(0,0,1),   ma(0,0,28,30'h20000000,30'h3,0,0,0), 0});
        vecs.push_back('{mk(0,0,0),   mk(0,28,0),  ma(0,0,28,30'h20000000,30'h2,0,0,0), 0});
        vecs.push_back('{mk(0,30,0),  mk(0,0,0),   ma(0,0,30,30'h20000000,30'h1,0,0,0), 0});
        vecs.push_back('{mk(0,29,0),  mk(0,0,'h3FFFFFF), ma(0,0,29,30'h20000000,30'h1,0,0,0), 0});
        vecs.push_back('{mk(1,-100,0), mk(0,100,0), ma(0,1,100,30'h20000000,30'h1,1,0,0), 0});
        vecs.push_back('{mk(1,3,5),   mk(0,3,5),   ma(1,0,3,30'h20000028,30'h20000028,1,0,0), 0});
        vecs.push_back('{mk(1,7,3),   mk(0,100,0,0,1), ma(1,0,7,30'h20000018,30'h0,1,0,0), 0});
        vecs.push_back('{mk(0,5,0,0,1), mk(0,0,0,1,0), ma(0,0,0,30'h0,30'h0,0,1,0), 1});

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in1 = '0; in2 = '0;
        dummy.e = '0; dummy.kind = 0;
        @(negedge clk);
        tick(0, dummy, f);
        tick(0, dummy, f);
        reset = 1'b0;
        chk("reset_out_valid", 74'(out_valid), 74'd0);
        chk("reset_out", out, 74'd0);
        chk("reset_in_ready", 74'(in_ready), 74'd1);

        out_ready = 1'b1;
        foreach (vecs[i]) begin
            tx.e = vecs[i].e; tx.kind = vecs[i].kind;
            send(vecs[i].a, vecs[i].b, 1, tx);
            chk("latency_early", 74'(out_valid), 74'd0);
            tick(0, dummy, f);
            chk("latency_2", 74'(out_valid), 74'd1);
            tick(0, dummy, f);
        end

        out_ready = 1'b0;
        send(mk(0,10,1), mk(1,4,2), 0, dummy);
        send(mk(1,20,3), mk(0,25,4), 0, dummy);
        chk("bp_in_ready_low", 74'(in_ready), 74'd0);
        in1 = mk(0,-7,5); in2 = mk(0,-40,6); in_valid = 1'b1;
        tick(0, dummy, f);
        tick(0, dummy, f);
        chk("bp_no_accept", 74'(in_ready), 74'd0);
        out_ready = 1'b1;
        send(mk(0,-7,5), mk(0,-40,6), 0, dummy);
        send(mk(1,0,7), mk(1,0,8), 0, dummy);
        drain();

        out_ready = 1'b0;
        send(mk(0,3,9), mk(0,1,9), 0, dummy);
        send(mk(0,4,9), mk(0,2,9), 0, dummy);
        reset = 1'b1; in1 = mk(0,9,1); in2 = mk(0,8,1); in_valid = 1'b1;
        tick(0, dummy, f);
        reset = 1'b0; in_valid = 1'b0;
        chk("rst_mid_out_valid", 74'(out_valid), 74'd0);
        chk("rst_mid_out", out, 74'd0);
        chk("rst_mid_in_ready", 74'(in_ready), 74'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(0, dummy, f);
            chk("rst_no_stale", 74'(out_valid), 74'd0);
        end

        for (int i = 0; i < 600; i++) begin
            base = int'($urandom_range(0, 511)) - 256;
            a = rv(base);
            b = rv(base);
            if ($urandom_range(0, 5) == 0) b.scale = a.scale;
            if ($urandom_range(0, 10) == 0) b.fraction = a.fraction;
            in1 = a; in2 = b;
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick(0, dummy, f);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
